// File: rtl/bitrev_reorder_buf_if.sv
// bitrev_reorder_buf_if: streaming bundle for the bit-reversal reorder buffer.
//
// Input stream  : in_valid/in_ready handshake, in_data, in_last, rev_en (frame mode)
// Output stream : out_valid/out_ready handshake, out_data, out_idx, out_last
// Status        : frame_err (one-cycle framing-mismatch pulse)
//
// slave  modport: used by the buffer itself.
// master modport: used by the source/sink attached to the buffer.
interface bitrev_reorder_buf_if #(
    parameter int unsigned N  = 3,
    parameter int unsigned DW = 16
);
    logic              rev_en;
    logic              in_valid;
    logic              in_ready;
    logic [2*DW-1:0]   in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [2*DW-1:0]   out_data;
    logic [N-1:0]      out_idx;
    logic              out_last;
    logic              frame_err;

    modport slave (
        input  rev_en, in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last, frame_err
    );

    modport master (
        output rev_en, in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last, frame_err
    );
endinterface

// File: rtl/bitrev_reorder_buf.sv
// bitrev_reorder_buf: ping-pong frame buffer that replays each 2^N-sample frame
// either in natural order or in bit-reversed order (mode latched on the first
// beat of each frame).
//
// Ports:
//   clk_i   - single clock, all state updates on the rising edge
//   rst_ni  - synchronous active-low reset
//   bus_io  - bitrev_reorder_buf_if.slave: input stream, output stream, frame_err
module bitrev_reorder_buf #(
    parameter int unsigned N  = 3,
    parameter int unsigned DW = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    bitrev_reorder_buf_if.slave   bus_io
);

    localparam int unsigned Depth  = 1 << N;
    localparam logic [N-1:0] CntMax = '1;

    function automatic logic [N-1:0] bitrev(input logic [N-1:0] a);
        logic [N-1:0] r;
        for (int i = 0; i < int'(N); i++) begin
            r[i] = a[N-1-i];
        end
        return r;
    endfunction

    // Bank storage is never reset; the full flags alone decide what is valid.
    logic [2*DW-1:0] mem_q [2][Depth];

    logic [1:0]      full_q, full_d;
    logic [1:0]      mode_q, mode_d;
    logic            wr_bank_q, wr_bank_d;
    logic            rd_bank_q, rd_bank_d;
    logic [N-1:0]    wr_cnt_q, wr_cnt_d;
    logic [N-1:0]    rd_cnt_q, rd_cnt_d;
    logic            out_valid_q, out_valid_d;
    logic [2*DW-1:0] out_data_q, out_data_d;
    logic [N-1:0]    out_idx_q, out_idx_d;
    logic            out_last_q, out_last_d;
    logic            frame_err_q, frame_err_d;

    logic            in_ready;
    logic            wr_fire;
    logic            wr_end;
    logic            rd_load;
    logic            rd_end;
    logic [N-1:0]    rd_addr;

    assign in_ready = rst_ni & ~full_q[wr_bank_q];
    assign wr_fire  = bus_io.in_valid & in_ready;
    assign wr_end   = wr_fire & (wr_cnt_q == CntMax);
    // The output register refills whenever it is empty or being drained this cycle.
    assign rd_load  = full_q[rd_bank_q] & (~out_valid_q | bus_io.out_ready);
    assign rd_end   = rd_load & (rd_cnt_q == CntMax);
    assign rd_addr  = mode_q[rd_bank_q] ? bitrev(rd_cnt_q) : rd_cnt_q;

    always_comb begin
        full_d      = full_q;
        mode_d      = mode_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        // Framing is judged against wr_cnt only; in_last never moves a boundary.
        frame_err_d = wr_fire & (bus_io.in_last ^ (wr_cnt_q == CntMax));

        if (wr_fire) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
            if (wr_cnt_q == '0) begin
                mode_d[wr_bank_q] = bus_io.rev_en;
            end
            if (wr_end) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end

        // Writer and reader always sit on different banks when they touch a full
        // flag, so the set above and the clear below never hit the same bit.
        if (rd_load) begin
            out_data_d  = mem_q[rd_bank_q][rd_addr];
            out_idx_d   = rd_addr;
            out_last_d  = (rd_cnt_q == CntMax);
            out_valid_d = 1'b1;
            rd_cnt_d    = rd_cnt_q + 1'b1;
            if (rd_end) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
            end
        end else if (bus_io.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            full_q      <= '0;
            mode_q      <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            full_q      <= full_d;
            mode_q      <= mode_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_fire) begin
            mem_q[wr_bank_q][wr_cnt_q] <= bus_io.in_data;
        end
    end

    assign bus_io.in_ready  = in_ready;
    assign bus_io.out_valid = out_valid_q;
    assign bus_io.out_data  = out_data_q;
    assign bus_io.out_idx   = out_idx_q;
    assign bus_io.out_last  = out_last_q;
    assign bus_io.frame_err = frame_err_q;

endmodule

// File: doc/bitrev_reorder_buf.md
BITREV_REORDER_BUF -- requirements
Module: bitrev_reorder_buf

Interface
REQ-001 Parameter N, default 3, log2 of FFT frame length; frame = 2^N samples; legal range 1..12.
REQ-002 Parameter DW, default 16, width of one real component; a sample is complex {re,im} of 2*DW bits.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
REQ-005 rev_en  input  1  1 = bit-reversed readout, 0 = natural-order readout; sampled per frame.
REQ-006 in_valid  input  1  input sample present.
REQ-007 in_ready  output  1  block can accept an input sample.
REQ-008 in_data  input  2*DW  input sample.
REQ-009 in_last  input  1  source marks final sample of frame; used only for error checking.
REQ-010 out_valid  output  1  output sample present.
REQ-011 out_ready  input  1  sink accepts output sample.
REQ-012 out_data  output  2*DW  output sample.
REQ-013 out_idx  output  N  natural (write-order) index of the sample on out_data.
REQ-014 out_last  output  1  final sample of output frame.
REQ-015 frame_err  output  1  one-cycle pulse on framing mismatch.

Function
REQ-016 Storage: two banks (ping-pong), each 2^N x 2*DW; per-bank full flag, per-bank latched mode bit; wr_bank, rd_bank pointers; N-bit wr_cnt, rd_cnt.
REQ-017 in_ready = rst_n AND NOT full[wr_bank].
REQ-018 Input beat accepted when in_valid AND in_ready at a rising edge: in_data written to bank wr_bank at address wr_cnt; wr_cnt increments.
REQ-019 On an accepted beat with wr_cnt = 0, rev_en is latched as the mode of bank wr_bank; rev_en at all other beats is ignored.
REQ-020 On an accepted beat with wr_cnt = 2^N-1: full[wr_bank] set, wr_bank toggles, wr_cnt wraps to 0, all at the same edge.
REQ-021 Output register loads when full[rd_bank] AND (NOT out_valid OR out_ready): out_data = bank[rd_bank][A], A = bitrev(rd_cnt) if bank mode = 1 else rd_cnt; out_idx = A; out_last = (rd_cnt = 2^N-1); out_valid set; rd_cnt increments.
REQ-022 Load with rd_cnt = 2^N-1: full[rd_bank] cleared, rd_bank toggles, rd_cnt wraps to 0, same edge.
REQ-023 When out_valid AND out_ready and no load occurs at that edge, out_valid clears.
REQ-024 While out_valid AND NOT out_ready: out_data, out_idx, out_last held stable.
REQ-025 Latency: final input beat of a frame accepted at edge E -> first output sample of that frame loaded at edge E+1 (out_valid high from E+1), provided the output register is free.
REQ-026 Throughput: with in_valid and out_ready held high, one sample per clock on each side indefinitely; in_ready never deasserts.
REQ-027 Writer only writes a non-full bank and reader only reads a full bank, so set and clear of one full flag never coincide.
REQ-028 frame_err pulses high the cycle after an accepted beat where in_last = 1 with wr_cnt != 2^N-1, or in_last = 0 with wr_cnt = 2^N-1; frame boundaries follow wr_cnt only.
REQ-029 Both banks full: in_ready = 0 until the reader drains one bank (REQ-022).

Reset
REQ-030 With rst_n = 0 at a rising edge: wr_cnt = rd_cnt = 0, wr_bank = rd_bank = 0, both full flags and mode bits = 0, out_valid = 0, out_data = 0, out_idx = 0, out_last = 0, frame_err = 0.
REQ-031 Reset mid-operation discards all partial and complete frames; bank memory contents are not cleared.
REQ-032 in_ready is 0 while rst_n = 0 and 1 in the first cycle after reset release.

Verification (N=3, DW=16)
REQ-033 rev_en=1, in_data 0..7, in_last on beat 7, out_ready=1 -> out_data 0,4,2,6,1,5,3,7; out_idx equal; out_last only on 8th; out_valid first high one edge after beat 7.
REQ-034 rev_en=0, same stimulus -> out_data 0..7 in order; frame_err stays 0.
REQ-035 Three back-to-back frames, rev_en 1,0,1, in_valid and out_ready constant 1 -> in_ready constantly 1; each frame reordered per its own latched mode.
REQ-036 out_ready=0, 20 input beats offered -> in_ready drops after 16 accepted; out_data/out_idx frozen; releasing out_ready yields both frames intact, then beats 17-20 accepted.
REQ-037 in_last asserted on beat 5 of a frame -> frame_err single-cycle pulse; frame still closes after beat 7; output order unaffected.
REQ-038 rst_n low for one edge after 5 beats of a frame -> all REQ-030 values; next 8-beat frame output correctly with no residue of the aborted frame.
